alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares the four-lane vector ALU between two instruction requesters: port 0 is the main decode pipeline, port 1 is the auxiliary/microcode sequencer.
- Accepts one ALU instruction at a time and issues it to the ALU control FSM as a single-cycle alu_start pulse, holding alu_op stable.
- Waits for alu_rdy, then returns a tagged completion to the owning requester.
- Also screens out illegal opcodes and recovers from a hung ALU with a timeout.

Parameters:
TAG_W, 4, width of requester tag passed through to the completion.
TIMEOUT, 15, maximum WAIT cycles without alu_rdy before forced error completion (1..255).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an instruction
req0_op  in  4  requester 0 ALU instruction opcode (0000..1101 legal)
req0_tag  in  TAG_W  requester 0 tag
req0_ready  out  1  requester 0 instruction accepted this cycle
req1_valid  in  1  requester 1 has an instruction
req1_op  in  4  requester 1 opcode
req1_tag  in  TAG_W  requester 1 tag
req1_ready  out  1  requester 1 instruction accepted this cycle
alu_start  out  1  one-cycle start pulse to ALU control
alu_op  out  4  opcode to ALU control, held stable from ISSUE through WAIT
alu_rdy  in  1  ALU control completion pulse
busy  out  1  high in every state except IDLE
done_valid  out  1  one-cycle completion pulse
done_id  out  1  requester owning the completion
done_tag  out  TAG_W  tag of completed instruction
done_err  out  1  1 = illegal opcode or timeout

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - All outputs 0, alu_op=0000.
  - rr_last=1, so requester 0 wins the first tie.
  - Timeout counter=0.
  - Reset asserted in any state, including mid-WAIT, aborts the operation; no done_valid is produced for it.
- Handshake:
  - A request is transferred when reqN_valid && reqN_ready.
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester.
  - Requesters hold valid/op/tag stable until ready.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester != rr_last is granted.
  - rr_last is updated to the granted id on every accept, including illegal ops.
- States:
  - IDLE:
    - On accept, latch op, tag and id.
    - If op is 1110 or 1111 -> DONE with err=1; no alu_start is issued.
    - Otherwise -> ISSUE.
    - With no valid request, stay in IDLE.
  - ISSUE:
    - alu_start=1 and alu_op=latched op for exactly one cycle.
    - Clear the timeout counter. -> WAIT.
  - WAIT:
    - alu_start=0; alu_op is still held.
    - If alu_rdy=1 -> DONE with err=0.
    - Otherwise increment the counter; when the counter reaches TIMEOUT, -> DONE with err=1.
    - If alu_rdy arrives in the same cycle the counter would reach TIMEOUT, alu_rdy wins (err=0).
  - DONE:
    - done_valid=1 for one cycle, with done_id/done_tag/done_err from the latched values. -> IDLE.
- alu_rdy is ignored in IDLE, ISSUE and DONE; a stray pulse has no effect.
- alu_op keeps its last value after DONE until the next ISSUE. ALU control samples it combinationally through Phase1/Phase2, so it must not change before alu_rdy.
- Latency, with an ALU that returns alu_rdy 3 cycles after start (Waiting->Phase1->Phase2->Ready):
  - accept at cycle t;
  - alu_start at t+1;
  - alu_rdy at t+4;
  - done_valid at t+5;
  - next accept possible at t+6.
- Illegal op: accept at t, done_valid at t+1.
- Timeout: done_valid at t+1+TIMEOUT+1 after the accept cycle boundary. Exact count: alu_start at t+1, TIMEOUT WAIT cycles at t+2..t+1+TIMEOUT, done_valid at t+2+TIMEOUT.
- No internal queue: at most one instruction in flight. Requesters see backpressure through ready.

Test Plan:
- Reset, then req0 op=0001 tag=3 alone, ALU model rdy 3 cycles after start:
  - req0_ready at t, alu_start=1 with alu_op=0001 at t+1, alu_op=0001 through t+4;
  - done_valid at t+5 with id=0, tag=3, err=0.
- req0 and req1 both valid continuously (ops 1010/1100, tags 1/2), four completions:
  - grant order 0,1,0,1;
  - done_id alternates; no two ready pulses in the same cycle.
- req1 op=1110 tag=7:
  - no alu_start pulse;
  - done_valid one cycle after accept with id=1, tag=7, err=1.
- TIMEOUT=15, ALU model never asserts rdy:
  - done_valid with err=1 exactly 17 cycles after accept;
  - next request is accepted afterwards normally.
- Reset asserted on the 2nd WAIT cycle:
  - next cycle all outputs 0 and state IDLE;
  - no done_valid for the aborted op;
  - a subsequent req1/req0 tie grants req0.
- alu_rdy pulse injected in IDLE and ISSUE: no state change, no done_valid. alu_rdy on the same cycle the counter hits TIMEOUT: err=0.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Two-requester issue arbiter for the shared four-lane vector ALU: round-robin grant,
// single-cycle start pulse, tagged completion, illegal-opcode screening and hung-ALU timeout.
module alu_issue_arbiter #(
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [3:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [3:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             req1_ready,
   output logic             alu_start,
   output logic [3:0]       alu_op,
   input  logic             alu_rdy,
   output logic             busy,
   output logic             done_valid,
   output logic             done_id,
   output logic [TAG_W-1:0] done_tag,
   output logic             done_err,
   output logic [1:0]       dbg_state
);

   // Handshake: a request transfers on reqN_valid && reqN_ready; ready is combinational,
   // high only in IDLE for the granted requester; requesters hold valid/op/tag until ready.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t           state, state_n;
   logic             rr_last;
   logic             id_q;
   logic             err_q;
   logic [TAG_W-1:0] tag_q;
   logic [7:0]       cnt;

   logic             grant0, grant1, accept, acc_id, acc_illegal, timeout_hit;
   logic [3:0]       acc_op;
   logic [TAG_W-1:0] acc_tag;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0 = rr_last;
            grant1 = !rr_last;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign accept      = grant0 | grant1;
   assign acc_id      = grant1;
   assign acc_op      = grant1 ? req1_op : req0_op;
   assign acc_tag     = grant1 ? req1_tag : req0_tag;
   assign acc_illegal = acc_op[3] & acc_op[2] & acc_op[1];
   assign timeout_hit = (cnt + 8'd1) == TIMEOUT_C;
   assign dbg_state   = state;

   always_comb begin
      state_n    = state;
      req0_ready = grant0;
      req1_ready = grant1;
      alu_start  = 1'b0;
      busy       = (state != IDLE);
      done_valid = 1'b0;
      done_id    = 1'b0;
      done_tag   = '0;
      done_err   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_n = acc_illegal ? DONE : ISSUE;
         end
         ISSUE: begin
            alu_start = 1'b1;
            state_n   = WAIT;
         end
         WAIT: begin
            // alu_rdy on the same cycle as the timeout still counts as success
            if (alu_rdy || timeout_hit) state_n = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            done_id    = id_q;
            done_tag   = tag_q;
            done_err   = err_q;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         id_q    <= 1'b0;
         tag_q   <= '0;
         err_q   <= 1'b0;
         alu_op  <= 4'b0000;
         cnt     <= 8'd0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (accept) begin
                  rr_last <= acc_id;
                  id_q    <= acc_id;
                  tag_q   <= acc_tag;
                  err_q   <= acc_illegal;
                  // ALU control keeps sampling alu_op, so only a real issue may change it
                  if (!acc_illegal) alu_op <= acc_op;
               end
            end
            ISSUE: cnt <= 8'd0;
            WAIT: begin
               if (!alu_rdy) begin
                  cnt <= cnt + 8'd1;
                  if (timeout_hit) err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: timing/ordering reference model feeding an expected-completion
// queue, an ALU stub with programmable latency and stray alu_rdy pulses, and a monitor.
module tb_alu_issue_arbiter;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int EW      = 32 + 2 + TAG_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]       req0_op = '0, req1_op = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             req0_ready, req1_ready;
  logic             alu_start, alu_rdy = 1'b0;
  logic [3:0]       alu_op;
  logic             busy, done_valid, done_id, done_err;
  logic [TAG_W-1:0] done_tag;
  logic [1:0]       dbg_state;

  alu_issue_arbiter #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .alu_start(alu_start), .alu_op(alu_op), .alu_rdy(alu_rdy), .busy(busy),
    .done_valid(done_valid), .done_id(done_id), .done_tag(done_tag), .done_err(done_err),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int   n_checks = 0, n_fail = 0;
  int   last_done = -1, exp_start = -1, rdy_cyc = -1;
  int   wait_lo = 0, wait_hi = -1, op_from = 0;
  int   force_delay = -1, n_acc = 0;
  logic model_rr = 1'b1;
  logic [3:0] last_legal_op = '0;
  logic took0 = 1'b0, took1 = 1'b0, rst_chk = 1'b0, stray_en = 1'b1;

  // monitor scratch
  int   m_g, m_d, m_done;
  logic m_idle, m_err, m_exp_dv;
  logic [3:0] m_op;
  logic [TAG_W-1:0] m_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TIMEOUT;
    if (r == 1) return TIMEOUT + 5;
    return int'($urandom_range(1, 5));
  endfunction

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'(14 + $urandom_range(0, 1));
    return 4'($urandom_range(0, 13));
  endfunction

  // scoreboard monitor: expectations pushed on accept, popped when done_valid appears
  always @(negedge clk) begin
    took0 = req0_ready;
    took1 = req1_ready;
    if (reset) begin
      exp_q.delete();
      model_rr = 1'b1; last_done = cyc; exp_start = -1; rdy_cyc = -1;
      wait_lo = 0; wait_hi = -1; last_legal_op = '0; op_from = cyc + 1;
      rst_chk = 1'b1;
    end else begin
      if (rst_chk) begin
        chk("reset_outputs", 32'({alu_start, alu_op, busy, done_valid, done_id, done_err, done_tag, dbg_state}), 32'd0);
        rst_chk = 1'b0;
      end
      m_idle = (cyc > last_done);
      m_g = -1;
      if (m_idle) begin
        if (req0_valid && req1_valid) m_g = model_rr ? 0 : 1;
        else if (req0_valid) m_g = 0;
        else if (req1_valid) m_g = 1;
      end
      chk("ready", 32'({req1_ready, req0_ready}), 32'({m_g == 1, m_g == 0}));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("alu_start", 32'(alu_start), 32'(cyc == exp_start));
      if (cyc >= op_from) chk("alu_op", 32'(alu_op), 32'(last_legal_op));

      m_exp_dv = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == cyc);
      chk("done_valid", 32'(done_valid), 32'(m_exp_dv));
      if (m_exp_dv) begin
        e = exp_q.pop_front();
        chk("done_id", 32'(done_id), 32'(e[TAG_W]));
        chk("done_tag", 32'(done_tag), 32'(e[TAG_W-1:0]));
        chk("done_err", 32'(done_err), 32'(e[TAG_W+1]));
      end
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) void'(exp_q.pop_front());

      if (m_g >= 0) begin
        m_op  = (m_g == 1) ? req1_op : req0_op;
        m_tag = (m_g == 1) ? req1_tag : req0_tag;
        m_d   = (force_delay >= 0) ? force_delay : pick_delay();
        if (m_op >= 4'd14) begin
          m_done = cyc + 1; m_err = 1'b1;
          wait_lo = 0; wait_hi = -1; rdy_cyc = -1;
        end else begin
          if (m_d <= TIMEOUT) begin
            m_done = cyc + 2 + m_d; m_err = 1'b0; rdy_cyc = cyc + 1 + m_d;
          end else begin
            m_done = cyc + 2 + TIMEOUT; m_err = 1'b1; rdy_cyc = -1;
          end
          exp_start = cyc + 1; last_legal_op = m_op; op_from = cyc + 1;
          wait_lo = cyc + 2; wait_hi = m_done - 1;
        end
        exp_q.push_back({32'(m_done), m_err, m_g == 1, m_tag});
        model_rr = (m_g == 1);
        last_done = m_done;
        n_acc++;
      end
    end
  end

  // ALU stub: programmed completion plus stray pulses outside the expected WAIT window
  initial forever begin
    @(posedge clk); #1;
    alu_rdy = (cyc == rdy_cyc) ||
              (stray_en && !(cyc >= wait_lo && cyc <= wait_hi) && ($urandom_range(0, 3) == 0));
  end

  // driver tasks
  task automatic send(input logic id, input logic [3:0] op, input logic [TAG_W-1:0] tag, input int dly);
    int n;
    @(posedge clk); #1;
    force_delay = dly;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_tag = tag; end
    else begin req0_valid = 1'b1; req0_op = op; req0_tag = tag; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 200);
    chk("accept_wait", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; force_delay = -1;
  endtask

  task automatic tie(input int count);
    int n, target;
    @(posedge clk); #1;
    force_delay = 3;
    req0_valid = 1'b1; req0_op = 4'b1010; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_op = 4'b1100; req1_tag = 4'd2;
    target = n_acc + count;
    n = 0;
    while (n_acc < target && n < 400) begin @(negedge clk); n++; end
    chk("tie_accepts", 32'(n_acc), 32'(target));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; force_delay = -1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc <= last_done && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    tie(4); wait_idle();
    send(1'b0, 4'b0001, 4'd3, 3); wait_idle();
    send(1'b1, 4'b1110, 4'd7, 3); wait_idle();
    send(1'b0, 4'b0011, 4'd9, TIMEOUT + 5); wait_idle();
    send(1'b1, 4'b0100, 4'd4, 2); wait_idle();
    send(1'b0, 4'b0101, 4'd6, TIMEOUT); wait_idle();

    // abort on the second WAIT cycle, then a tie must go to requester 0
    send(1'b0, 4'b0001, 4'd5, TIMEOUT + 5);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tie(1); wait_idle();

    repeat (800) begin
      @(posedge clk); #1;
      if (took0) req0_valid = 1'b0;
      if (took1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_valid = 1'b1; req0_op = rand_op(); req0_tag = 4'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_valid = 1'b1; req1_op = rand_op(); req1_tag = 4'($urandom);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected completion", cyc);
    $fatal(1);
  end
endmodule
